// File: rtl/sram_responder_pkg.sv
// Shared types and helpers for the LC-3 SRAM-strobe responder.
package sram_responder_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_HOLD = 3'd3,
        S_WR   = 3'd4
    } state_e;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // be[0] selects the low byte, be[1] the high byte (already active-high).
    function automatic logic [15:0] byte_merge(
        input logic [15:0] old_word,
        input logic [15:0] new_word,
        input logic [1:0]  be
    );
        byte_merge[7:0]  = be[0] ? new_word[7:0]  : old_word[7:0];
        byte_merge[15:8] = be[1] ? new_word[15:8] : old_word[15:8];
    endfunction

endpackage

// File: rtl/sram_bram_sp.sv
// Single-port synchronous RAM, 16-bit words, per-byte write enable, registered read.
module sram_bram_sp
    import sram_responder_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          Clk,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    we,
    input  logic [15:0]   wdata,
    input  logic          re,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [0:(1 << AW) - 1];
    logic [15:0] rdata_q;

    // Read port only updates when re is high so the last read word stays put.
    always_ff @(posedge Clk) begin
        if (we[0]) begin
            mem_q[addr][7:0] <= wdata[7:0];
        end
        if (we[1]) begin
            mem_q[addr][15:8] <= wdata[15:8];
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// LC-3 memory-side responder: on-chip RAM behind active-low SRAM strobes, I/O word, RAM clear.
// Optional access counters are built when SRAM_RESPONDER_ACCESS_COUNT_EN is defined.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_W = 10,
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic        Mem_CE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic [15:0] Hex_Out,
    output logic        Init_Done,
    output logic        Bus_Err,
    output logic [15:0] Rd_Count,
    output logic [15:0] Wr_Count
);

    localparam logic [DEPTH_W-1:0] CLR_ONE = {{(DEPTH_W - 1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] clr_cnt_q, clr_cnt_d;
    logic               init_done_q, init_done_d;
    logic               bus_err_q, bus_err_d;
    logic [15:0]        hex_q, hex_d;
    logic [15:0]        data_q, data_d;
    logic               src_ram_q, src_ram_d;

    logic               rd_req_s, wr_req_s, in_ram_s, io_hit_s;
    logic [1:0]         be_s;
    logic [DEPTH_W-1:0] ram_addr_s;
    logic [1:0]         ram_we_s, ram_we_gated_s;
    logic [15:0]        ram_wdata_s, ram_rdata_s;
    logic               ram_re_s, ram_re_gated_s;
    logic               rd_entry_s, wr_commit_s;

    assign rd_req_s = ~Mem_CE & ~Mem_OE & Mem_WE;
    assign wr_req_s = ~Mem_CE & ~Mem_WE;
    assign be_s     = {~Mem_UB, ~Mem_LB};
    assign in_ram_s = (ADDR >> DEPTH_W) == 16'd0;
    assign io_hit_s = (ADDR == IO_ADDR);

    // Next-state, write-commit and read-capture decisions.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        bus_err_d   = bus_err_q;
        hex_d       = hex_q;
        data_d      = data_q;
        src_ram_d   = src_ram_q;
        ram_addr_s  = ADDR[DEPTH_W-1:0];
        ram_we_s    = 2'b00;
        ram_wdata_s = Data_from_CPU;
        ram_re_s    = 1'b0;
        rd_entry_s  = 1'b0;
        wr_commit_s = 1'b0;

        case (state_q)
            S_INIT: begin
                ram_addr_s  = clr_cnt_q;
                ram_we_s    = 2'b11;
                ram_wdata_s = 16'h0000;
                clr_cnt_d   = clr_cnt_q + CLR_ONE;
                if (&clr_cnt_q) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_IDLE: begin
                if (wr_req_s) begin
                    state_d = S_WR;
                    if (!Mem_OE) begin
                        bus_err_d = 1'b1;
                    end else begin
                        bus_err_d = bus_err_q;
                    end
                    if (io_hit_s) begin
                        hex_d       = byte_merge(hex_q, Data_from_CPU, be_s);
                        wr_commit_s = (be_s != 2'b00);
                    end else if (in_ram_s) begin
                        ram_we_s    = be_s;
                        wr_commit_s = (be_s != 2'b00);
                    end else begin
                        wr_commit_s = 1'b0;
                    end
                end else if (rd_req_s) begin
                    // RAM word arrives on the RAM's own output register next cycle.
                    state_d    = S_RD;
                    rd_entry_s = 1'b1;
                    src_ram_d  = ~io_hit_s & in_ram_s;
                    ram_re_s   = ~io_hit_s & in_ram_s;
                    data_d     = io_hit_s ? Switches : 16'h0000;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD, S_HOLD: begin
                if (wr_req_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_WR;
                end else if (rd_req_s) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (wr_req_s) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Reset aborts any RAM access in flight.
    assign ram_we_gated_s = Reset ? 2'b00 : ram_we_s;
    assign ram_re_gated_s = Reset ? 1'b0 : ram_re_s;

    // Control and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
            hex_q       <= 16'h0000;
            data_q      <= 16'h0000;
            src_ram_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            bus_err_q   <= bus_err_d;
            hex_q       <= hex_d;
            data_q      <= data_d;
            src_ram_q   <= src_ram_d;
        end
    end

    sram_bram_sp #(
        .AW (DEPTH_W)
    ) u_ram (
        .Clk   (Clk),
        .addr  (ram_addr_s),
        .we    (ram_we_gated_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_gated_s),
        .rdata (ram_rdata_s)
    );

    assign Data_to_CPU = src_ram_q ? ram_rdata_s : data_q;
    assign Hex_Out     = hex_q;
    assign Init_Done   = init_done_q;
    assign Bus_Err     = bus_err_q;

`ifdef SRAM_RESPONDER_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Saturating access counters.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_entry_s && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
        if (wr_commit_s && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign Rd_Count = rd_count_q;
    assign Wr_Count = wr_count_q;
`else
    logic unused_cnt_s;
    assign unused_cnt_s = rd_entry_s ^ wr_commit_s;
    assign Rd_Count     = 16'h0000;
    assign Wr_Count     = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder with a 16-word RAM.
module tb_sram_responder;

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [15:0] Data_from_CPU;
    logic [15:0] Switches;
    logic [15:0] Data_to_CPU;
    logic [15:0] Hex_Out;
    logic        Init_Done;
    logic        Bus_Err;
    logic [15:0] Rd_Count;
    logic [15:0] Wr_Count;

    int checks = 0;
    int errors = 0;

    sram_responder #(
        .DEPTH_W (4),
        .IO_ADDR (16'hFFFF)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ADDR          (ADDR),
        .Mem_CE        (Mem_CE),
        .Mem_UB        (Mem_UB),
        .Mem_LB        (Mem_LB),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .Data_from_CPU (Data_from_CPU),
        .Switches      (Switches),
        .Data_to_CPU   (Data_to_CPU),
        .Hex_Out       (Hex_Out),
        .Init_Done     (Init_Done),
        .Bus_Err       (Bus_Err),
        .Rd_Count      (Rd_Count),
        .Wr_Count      (Wr_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic bus_idle();
        Mem_CE = 1'b1;
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
    endtask

    // Starts and ends on a negedge; WE low for three cycles.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic ub, input logic lb);
        ADDR = a;
        Data_from_CPU = d;
        Mem_CE = 1'b0;
        Mem_WE = 1'b0;
        Mem_UB = ub;
        Mem_LB = lb;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        bus_idle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // OE low for two cycles; returns the value seen in the second OE-low cycle.
    task automatic do_read(input logic [15:0] a, output logic [15:0] d);
        ADDR = a;
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        d = Data_to_CPU;
        @(posedge Clk);
        @(negedge Clk);
        bus_idle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic count_init(input string name);
        int cnt;
        cnt = 0;
        while (!Init_Done && cnt < 40) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL %s: init cycles got %0d expected 16", name, cnt);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        @(negedge Clk);
        bus_idle();
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Data_to_CPU, Hex_Out, Init_Done, Bus_Err} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%b/%b expected 0", Data_to_CPU, Hex_Out, Init_Done, Bus_Err);
        end
        Reset = 1'b0;
        count_init("init_len");
        for (int i = 0; i < 16; i++) begin
            do_read(16'(i), d);
            checks++;
            if (d !== 16'h0000) begin
                errors++;
                $display("FAIL cleared_word[%0d]: got %h expected 0000", i, d);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] d;
        do_write(16'h0003, 16'hBEEF, 1'b0, 1'b0);
        do_read(16'h0003, d);
        checks++;
        if (d !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_read: got %h expected BEEF", d);
        end
`ifdef SRAM_RESPONDER_ACCESS_COUNT_EN
        checks++;
        if (Wr_Count !== 16'd1 || Rd_Count !== 16'd17) begin
            errors++;
            $display("FAIL counters: got rd=%0d wr=%0d expected rd=17 wr=1", Rd_Count, Wr_Count);
        end
`else
        checks++;
        if (Wr_Count !== 16'd0 || Rd_Count !== 16'd0) begin
            errors++;
            $display("FAIL counters_off: got rd=%0d wr=%0d expected 0", Rd_Count, Wr_Count);
        end
`endif
    endtask

    task automatic test_byte_write();
        logic [15:0] d;
        do_write(16'h0003, 16'h1234, 1'b1, 1'b0);
        do_read(16'h0003, d);
        checks++;
        if (d !== 16'hBE34) begin
            errors++;
            $display("FAIL byte_write_lo: got %h expected BE34", d);
        end
        do_write(16'h0004, 16'hAB00, 1'b0, 1'b1);
        do_read(16'h0004, d);
        checks++;
        if (d !== 16'hAB00) begin
            errors++;
            $display("FAIL byte_write_hi: got %h expected AB00", d);
        end
    endtask

    task automatic test_io();
        logic [15:0] d;
        Switches = 16'h00A5;
        do_read(16'hFFFF, d);
        checks++;
        if (d !== 16'h00A5) begin
            errors++;
            $display("FAIL switch_read: got %h expected 00A5", d);
        end
        do_write(16'hFFFF, 16'hC0DE, 1'b0, 1'b0);
        checks++;
        if (Hex_Out !== 16'hC0DE) begin
            errors++;
            $display("FAIL hex_write: got %h expected C0DE", Hex_Out);
        end
        do_write(16'h0020, 16'h5555, 1'b0, 1'b0);
        do_read(16'h0020, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL out_of_range_read: got %h expected 0000", d);
        end
        do_read(16'h0000, d);
        checks++;
        if (d !== 16'h0000 || Hex_Out !== 16'hC0DE) begin
            errors++;
            $display("FAIL dropped_write: got word0=%h hex=%h expected 0000/C0DE", d, Hex_Out);
        end
    endtask

    task automatic test_hold();
        ADDR = 16'h0003;
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        ADDR = 16'hFFFF;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Data_to_CPU !== 16'hBE34) begin
            errors++;
            $display("FAIL hold_no_reread: got %h expected BE34", Data_to_CPU);
        end
        bus_idle();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Data_to_CPU !== 16'hBE34) begin
            errors++;
            $display("FAIL hold_release: got %h expected BE34", Data_to_CPU);
        end
    endtask

    task automatic test_bus_err();
        logic [15:0] d;
        checks++;
        if (Bus_Err !== 1'b0) begin
            errors++;
            $display("FAIL bus_err_clear: got %b expected 0", Bus_Err);
        end
        ADDR = 16'h0005;
        Data_from_CPU = 16'h7777;
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        bus_idle();
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Bus_Err !== 1'b1) begin
            errors++;
            $display("FAIL bus_err_set: got %b expected 1", Bus_Err);
        end
        do_read(16'h0005, d);
        checks++;
        if (d !== 16'h7777 || Bus_Err !== 1'b1) begin
            errors++;
            $display("FAIL bus_err_write: got %h err=%b expected 7777 err=1", d, Bus_Err);
        end
    endtask

    task automatic test_reset_hold();
        logic [15:0] d;
        ADDR = 16'h0003;
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Data_to_CPU, Hex_Out, Init_Done, Bus_Err} !== 34'd0) begin
            errors++;
            $display("FAIL reset_in_hold: got %h/%h/%b/%b expected 0", Data_to_CPU, Hex_Out, Init_Done, Bus_Err);
        end
        bus_idle();
        Reset = 1'b0;
        count_init("reinit_len");
        do_read(16'h0003, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL reinit_clear: got %h expected 0000", d);
        end
    endtask

    task automatic test_write_in_hold();
        logic [15:0] d;
        ADDR = 16'h0006;
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Data_from_CPU = 16'h9999;
        Mem_WE = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        bus_idle();
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Bus_Err !== 1'b1) begin
            errors++;
            $display("FAIL hold_write_err: got %b expected 1", Bus_Err);
        end
        do_read(16'h0006, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL hold_write_ignored: got %h expected 0000", d);
        end
    endtask

    initial begin
        Reset = 1'b1;
        ADDR = 16'h0000;
        Data_from_CPU = 16'h0000;
        Switches = 16'h0000;
        bus_idle();
        test_reset();
        test_write_read();
        test_byte_write();
        test_io();
        test_hold();
        test_bus_err();
        test_reset_hold();
        test_write_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Memory-side responder for the LC-3 control unit's asynchronous-SRAM-style strobe interface (Mem_CE/UB/LB/OE/WE, all active-low). It wraps an on-chip synchronous RAM and returns read data within the fixed two-cycle read window the control unit uses: OE is held low for two cycles, and MDR loads in the second cycle.
It also provides one memory-mapped I/O word at 0xFFFF (switches on read, hex register on write) and zero-initialises the RAM after reset.

Parameters:
DEPTH_W, 10, log2 of RAM depth in 16-bit words; valid addresses are 0 to 2^DEPTH_W-1.
IO_ADDR, 16'hFFFF, memory-mapped I/O address.

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
ADDR  in  16  word address (MAR)
Mem_CE  in  1  chip enable, active-low
Mem_UB  in  1  upper-byte enable, active-low
Mem_LB  in  1  lower-byte enable, active-low
Mem_OE  in  1  read strobe, active-low
Mem_WE  in  1  write strobe, active-low
Data_from_CPU  in  16  write data (MDR)
Switches  in  16  value returned for reads of IO_ADDR
Data_to_CPU  out  16  read data, registered
Hex_Out  out  16  I/O register written at IO_ADDR
Init_Done  out  1  high once the RAM clear completes
Bus_Err  out  1  sticky protocol-error flag
Rd_Count  out  16  read-access counter (optional feature)
Wr_Count  out  16  write-access counter (optional feature)

Behaviour:
- Reset: synchronous, active-high; clock Clk. All outputs reset to 0; the state machine goes to S_INIT and the clear counter goes to 0. Reset asserted mid-operation aborts any access and restarts the clear.
- Decoding: rd_req = ~Mem_CE & ~Mem_OE & Mem_WE. wr_req = ~Mem_CE & ~Mem_WE.
- S_INIT:
  - Writes 0 to address clr_cnt each cycle; clr_cnt increments.
  - After 2^DEPTH_W cycles, Init_Done rises and the state goes to S_IDLE.
  - All strobes are ignored and Data_to_CPU is held at 0.
- S_IDLE:
  - wr_req goes to S_WR. Write takes priority; if OE is also low, Bus_Err sets.
  - Otherwise rd_req goes to S_RD.
  - Otherwise the state stays in S_IDLE.
- Write commit: happens on the entry cycle (the IDLE cycle in which wr_req is seen), exactly once per strobe.
  - Mem_LB low writes bits 7:0; Mem_UB low writes bits 15:8. Both high means no write.
  - Address IO_ADDR writes Hex_Out, byte-masked the same way.
  - Any other address at or above 2^DEPTH_W is dropped.
- S_WR: stays while wr_req is held (no repeated commit); returns to S_IDLE when WE rises.
- Read timing:
  - S_RD is entered on the first OE-low cycle. In that cycle the RAM address = ADDR.
  - At the end of the cycle Data_to_CPU registers, by address:
    - RAM address: RAM word.
    - IO_ADDR: Switches.
    - Out of range: 0.
  - Result: data is valid during the second OE-low cycle. Latency is 1 clock from strobe to valid.
  - Byte enables do not mask reads.
- S_RD goes to S_HOLD while rd_req is held, else to S_IDLE.
- S_HOLD:
  - Data_to_CPU is held (no re-read even if ADDR changes); OE held low indefinitely is legal.
  - OE rises: go to S_IDLE, Data_to_CPU keeps its last value.
  - WE falls during S_RD/S_HOLD: Bus_Err sets, the write is ignored, and the state goes to S_WR without committing.
- Bus_Err clears only on Reset.

Optional Feature:
Macro SRAM_RESPONDER_ACCESS_COUNT_EN.
- Defined: Rd_Count increments on each S_RD entry; Wr_Count increments on each committed write, including I/O writes and excluding dropped ones. Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package sram_responder_pkg holds:
  - state enum (S_INIT, S_IDLE, S_RD, S_HOLD, S_WR);
  - IO_ADDR default constant;
  - function for byte-merge.
- One sub-module, sram_bram_sp: a single-port synchronous RAM with a 2-bit byte-write enable and registered read. This lets synthesis infer block RAM.

Test Plan (DEPTH_W=4):
1. Reset, then count cycles → Init_Done rises after exactly 16 cycles; reads of addresses 0..15 all return 16'h0000.
2. Write ADDR=3, data 16'hBEEF, UB=LB=0, WE low 3 cycles; then read ADDR=3 with OE low 2 cycles → Data_to_CPU=16'hBEEF in the 2nd cycle; Wr_Count=1 when the feature is enabled.
3. Write ADDR=3, data 16'h1234 with UB=1, LB=0, then read → 16'hBE34.
4. Switches=16'h00A5; read ADDR=16'hFFFF → 16'h00A5. Write 16'hC0DE to 16'hFFFF → Hex_Out=16'hC0DE. Write 16'h5555 to ADDR=16'h0020 → dropped, and a read of ADDR=16'h0020 → 16'h0000.
5. OE and WE both low in IDLE with ADDR=5, data 16'h7777 → write commits, Bus_Err=1 until Reset.
6. Reset asserted during S_HOLD → Data_to_CPU=0, Hex_Out=0, Init_Done=0, and the clear restarts (16 cycles).
